// File: rtl/led_pattern_seq.sv
// led_pattern_seq: steps a WIDTH-bit LED pattern once per qualifying
// transition of the slow divider level, all in the clk_in domain.
//
// Ports:
//   clk_in  - system clock, rising edge
//   rst     - synchronous active-high reset
//   slow_in - slow toggling level, synchronous to clk_in
//   mode    - 0 BLINK, 1 ROTATE, 2 BOUNCE, 3 COUNT
//   pause   - high discards pattern steps
//   led     - registered LED bank
//   step    - one-cycle pulse after each pattern advance
//   dir     - BOUNCE direction, 0 toward MSB, 1 toward LSB
//
// Build option: define LED_SEQ_BOTH_EDGES_EN to step on both
// rising and falling slow_in transitions (default: rising only).

module led_pattern_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             slow_in,
   input  logic [1:0]       mode,
   input  logic             pause,
   output logic [WIDTH-1:0] led,
   output logic             step,
   output logic             dir
);

   typedef enum logic [1:0] {
      M_BLINK  = 2'd0,
      M_ROTATE = 2'd1,
      M_BOUNCE = 2'd2,
      M_COUNT  = 2'd3
   } mode_t;

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   mode_t mode_q;
   mode_t mode_n;
   logic  prev;
   logic  armed;
   logic  slow_edge;
   logic  do_step;

   assign mode_n = mode_t'(mode);

`ifdef LED_SEQ_BOTH_EDGES_EN
   assign slow_edge = armed & (slow_in ^ prev);
`else
   assign slow_edge = armed & slow_in & ~prev;
`endif

   assign do_step = slow_edge & ~pause;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         led    <= '0;
         step   <= 1'b0;
         dir    <= 1'b0;
         mode_q <= M_BLINK;
         armed  <= 1'b0;
         prev   <= 1'b0;
      end else begin
         step <= 1'b0;
         prev <= slow_in;
         // First cycle out of reset only captures the level,
         // so a high slow_in never produces a spurious step.
         if (!armed) begin
            armed <= 1'b1;
         end else if (do_step) begin
            step <= 1'b1;
            if (mode_n != mode_q) begin
               mode_q <= mode_n;
               unique case (mode_n)
                  M_BLINK:  led <= ONES;
                  M_ROTATE: led <= ONE;
                  M_BOUNCE: begin
                     led <= ONE;
                     dir <= 1'b0;
                  end
                  M_COUNT:  led <= '0;
               endcase
            end else begin
               unique case (mode_q)
                  M_BLINK:  led <= ~led;
                  M_ROTATE: led <= {led[WIDTH-2:0], led[WIDTH-1]};
                  M_BOUNCE: begin
                     // Reverse at the ends so each end LED is
                     // lit for exactly one step.
                     if (!dir) begin
                        if (led[WIDTH-1]) begin
                           dir <= 1'b1;
                           led <= led >> 1;
                        end else begin
                           led <= led << 1;
                        end
                     end else begin
                        if (led[0]) begin
                           dir <= 1'b0;
                           led <= led << 1;
                        end else begin
                           led <= led >> 1;
                        end
                     end
                  end
                  M_COUNT:  led <= led + ONE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed, table-driven bench for
// led_pattern_seq with WIDTH = 8.

module tb_led_pattern_seq;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       slow_in;
   logic [1:0] mode;
   logic       pause;
   logic [7:0] led;
   logic       step;
   logic       dir;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] m;
      logic       p;
      logic [7:0] led;
      logic       stp;
      logic       d;
   } vec_t;

   vec_t tv[$];

   logic [7:0] bseq [16] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02
   };

   led_pattern_seq #(.WIDTH(8)) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .slow_in (slow_in),
      .mode    (mode),
      .pause   (pause),
      .led     (led),
      .step    (step),
      .dir     (dir)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One qualifying slow_in transition; sample right after it.
   task automatic qual(input logic [1:0] m, input logic p);
      mode  = m;
      pause = p;
`ifdef LED_SEQ_BOTH_EDGES_EN
      slow_in = ~slow_in;
      tick();
`else
      if (slow_in) begin
         slow_in = 1'b0;
         tick();
      end
      slow_in = 1'b1;
      tick();
`endif
   endtask

   task automatic add(input logic [1:0] m, input logic p,
                      input logic [7:0] l, input logic s,
                      input logic d);
      vec_t v;
      v.m = m; v.p = p; v.led = l; v.stp = s; v.d = d;
      tv.push_back(v);
   endtask

   initial begin
      int nsteps;

      for (int i = 0; i < 16; i++)
         add(2'd2, 1'b0, bseq[i], 1'b1, (i >= 8 && i <= 14));
      add(2'd1, 1'b0, 8'h01, 1'b1, 1'b0);
      add(2'd1, 1'b0, 8'h02, 1'b1, 1'b0);
      add(2'd1, 1'b1, 8'h02, 1'b0, 1'b0);
      add(2'd1, 1'b1, 8'h02, 1'b0, 1'b0);
      add(2'd1, 1'b1, 8'h02, 1'b0, 1'b0);
      add(2'd1, 1'b0, 8'h04, 1'b1, 1'b0);
      add(2'd0, 1'b0, 8'hff, 1'b1, 1'b0);
      add(2'd0, 1'b0, 8'h00, 1'b1, 1'b0);

      rst     = 1'b1;
      slow_in = 1'b1;
      mode    = 2'd0;
      pause   = 1'b0;
      tick();
      tick();
      chk("rst_led", led, 8'h00);
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);

      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("arm_step", step, 0);
         chk("arm_led", led, 8'h00);
      end

      foreach (tv[i]) begin
         qual(tv[i].m, tv[i].p);
         chk($sformatf("vec%0d_led", i), led, tv[i].led);
         chk($sformatf("vec%0d_step", i), step, tv[i].stp);
         chk($sformatf("vec%0d_dir", i), dir, tv[i].d);
      end

      tick();
      chk("step_clear", step, 0);

      mode = 2'd1;
      tick();
      tick();
      chk("mode_no_edge_led", led, 8'h00);
      chk("mode_no_edge_step", step, 0);

      qual(2'd3, 1'b0);
      chk("count_load", led, 8'h00);
      for (int i = 1; i <= 255; i++) begin
         qual(2'd3, 1'b0);
         if (i % 64 == 0 || i == 255)
            chk($sformatf("count_%0d", i), led, i);
      end
      qual(2'd3, 1'b0);
      chk("count_wrap_led", led, 8'h00);
      chk("count_wrap_step", step, 1);
      tick();
      chk("count_wrap_step_off", step, 0);
      chk("count_wrap_hold", led, 8'h00);

      // Mid-pattern reset, coincident with a transition.
      mode = 2'd2;
      qual(2'd2, 1'b0);
      chk("pre_rst_led", led, 8'h01);
      rst = 1'b1;
      slow_in = ~slow_in;
      tick();
      chk("mid_rst_led", led, 8'h00);
      chk("mid_rst_step", step, 0);
      chk("mid_rst_dir", dir, 0);

      // Rearm with slow_in low, then rise and fall 20 cycles apart.
      slow_in = 1'b0;
      mode    = 2'd0;
      tick();
      rst = 1'b0;
      tick();
      chk("rearm_step", step, 0);
      nsteps = 0;
      slow_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         nsteps += int'(step);
      end
      chk("rise_led", led, 8'hff);
      slow_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         nsteps += int'(step);
      end
`ifdef LED_SEQ_BOTH_EDGES_EN
      chk("edge_steps", nsteps, 2);
      chk("fall_led", led, 8'h00);
`else
      chk("edge_steps", nsteps, 1);
      chk("fall_led", led, 8'hff);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
